// File: rtl/ray_dispatch_array_if.sv
// Upstream job and downstream ray-unit signal bundle for ray_dispatch_array.
// master = job source / unit array side, slave = dispatcher side.
interface ray_dispatch_array_if #(
  parameter int unsigned POSITION_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned NUM_UNITS      = 4
);
  logic                          flush;
  logic                          start;
  logic                          ready;
  logic                          busy;
  logic [3*POSITION_WIDTH-1:0]   rayQ;
  logic [3*POSITION_WIDTH-1:0]   rayV;
  logic [ADDRESS_WIDTH-1:0]      pixelAddress;
  logic [NUM_UNITS-1:0]          unitStart;
  logic [NUM_UNITS-1:0]          unitReady;
  logic [NUM_UNITS-1:0]          unitBusy;
  logic [3*POSITION_WIDTH-1:0]   unitRayQ;
  logic [3*POSITION_WIDTH-1:0]   unitRayV;
  logic [ADDRESS_WIDTH-1:0]      unitPixelAddress;

  modport master (
    output flush, start, rayQ, rayV, pixelAddress, unitReady, unitBusy,
    input  ready, busy, unitStart, unitRayQ, unitRayV, unitPixelAddress
  );

  modport slave (
    input  flush, start, rayQ, rayV, pixelAddress, unitReady, unitBusy,
    output ready, busy, unitStart, unitRayQ, unitRayV, unitPixelAddress
  );
endinterface

// File: rtl/ray_dispatch_array.sv
// Ray job FIFO with round-robin dispatch to NUM_UNITS ray units.
// Define RAY_DISPATCH_STATS_EN to add the dispatchCount/stallCount statistics ports.
module ray_dispatch_array #(
  parameter int unsigned POSITION_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ray_dispatch_array_if.slave  bus
`ifdef RAY_DISPATCH_STATS_EN
  ,
  output logic [31:0]          dispatchCount,
  output logic [31:0]          stallCount
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned RR_W  = $clog2(NUM_UNITS);

  typedef struct packed {
    logic [3*POSITION_WIDTH-1:0] ray_q;
    logic [3*POSITION_WIDTH-1:0] ray_v;
    logic [ADDRESS_WIDTH-1:0]    pixel_address;
  } job_t;

  job_t               mem_q [FIFO_DEPTH];
  job_t               mem_d [FIFO_DEPTH];
  job_t               head_c;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic               ready_c;
  logic               push_c;
  logic               dispatch_c;
  logic               grant_found_c;
  logic [RR_W-1:0]    grant_idx_c;
  logic [RR_W:0]      search_idx_c;
  logic [NUM_UNITS-1:0] unit_start_c;

  assign ready_c = (occ_q < OCC_W'(FIFO_DEPTH)) && !bus.flush;
  assign push_c  = bus.start && ready_c;

  // First ready unit at or above rr_ptr_q, wrapping past the top index.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    search_idx_c  = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      search_idx_c = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
      if (search_idx_c >= (RR_W+1)'(NUM_UNITS)) begin
        search_idx_c = search_idx_c - (RR_W+1)'(NUM_UNITS);
      end
      if (!grant_found_c && bus.unitReady[search_idx_c[RR_W-1:0]]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = search_idx_c[RR_W-1:0];
      end
    end
  end

  assign dispatch_c = (occ_q != '0) && !bus.flush && grant_found_c;

  always_comb begin
    unit_start_c = '0;
    if (dispatch_c) begin
      unit_start_c[grant_idx_c] = 1'b1;
    end
  end

  assign head_c               = mem_q[rd_ptr_q];
  assign bus.ready            = ready_c;
  assign bus.busy             = (occ_q != '0) || (|bus.unitBusy);
  assign bus.unitStart        = unit_start_c;
  assign bus.unitRayQ         = head_c.ray_q;
  assign bus.unitRayV         = head_c.ray_v;
  assign bus.unitPixelAddress = head_c.pixel_address;

  // Flush wins over push/pop; pointers wrap naturally at power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    rr_ptr_d = rr_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q] = '{ray_q: bus.rayQ, ray_v: bus.rayV, pixel_address: bus.pixelAddress};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (dispatch_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        rr_ptr_d = (grant_idx_c == RR_W'(NUM_UNITS - 1)) ? '0 : grant_idx_c + RR_W'(1);
      end
      if (push_c && !dispatch_c) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!push_c && dispatch_c) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Job storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef RAY_DISPATCH_STATS_EN
  logic [31:0] dispatch_cnt_q, dispatch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    dispatch_cnt_d = dispatch_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (dispatch_c && (dispatch_cnt_q != '1)) begin
      dispatch_cnt_d = dispatch_cnt_q + 32'd1;
    end
    if ((occ_q != '0) && !(|bus.unitReady) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dispatch_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      dispatch_cnt_q <= dispatch_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign dispatchCount = dispatch_cnt_q;
  assign stallCount    = stall_cnt_q;
`endif

endmodule

// File: doc/ray_dispatch_array.md
RAY_DISPATCH_ARRAY -- requirements
Module: ray_dispatch_array

Interface
REQ-001 SHALL have parameter POSITION_WIDTH, default 16, width of each ray coordinate component.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, width of pixel addresses.
REQ-003 SHALL have parameter NUM_UNITS, default 4, number of downstream ray units (legal range 2..16).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of buffered ray jobs (power of two, 2..16).
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports named clock and reset.
REQ-006 SHALL have ports as follows; name, direction, width, meaning:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered jobs.
- start  in  1  upstream job valid.
- ready  out  1  buffer can accept a job.
- busy  out  1  jobs buffered or any unit busy.
- rayQ  in  3 x POSITION_WIDTH  ray origin.
- rayV  in  3 x POSITION_WIDTH  ray direction.
- pixelAddress  in  ADDRESS_WIDTH  destination pixel.
- unitStart  out  NUM_UNITS  one-hot dispatch strobe.
- unitReady  in  NUM_UNITS  per-unit can-accept.
- unitBusy  in  NUM_UNITS  per-unit busy.
- unitRayQ, unitRayV  out  3 x POSITION_WIDTH  broadcast head-of-FIFO ray.
- unitPixelAddress  out  ADDRESS_WIDTH  broadcast head-of-FIFO pixel.
- dispatchCount, stallCount  out  32  statistics (present only with the macro, REQ-020).

Function
REQ-007 SHALL assert ready iff occupancy < FIFO_DEPTH and flush is low; ready is registered-state-derived, independent of this cycle's dispatch.
REQ-008 SHALL push {rayQ, rayV, pixelAddress} when start && ready; start without ready is ignored (no error, no storage).
REQ-009 SHALL, when occupancy > 0 and flush is low, grant the first index i with unitReady[i]=1, searching upward from rrPtr with wrap from NUM_UNITS-1 to 0.
REQ-010 SHALL drive unitStart one-hot on the granted index for exactly that cycle, with unit* data equal to the FIFO head, and pop the head in the same cycle.
REQ-011 SHALL update rrPtr to (grant+1) mod NUM_UNITS after each dispatch; with no dispatch, rrPtr holds.
REQ-012 SHALL keep unitStart all-zero when the FIFO is empty, no unitReady is set, or flush is high.
REQ-013 SHALL give a minimum latency of one cycle from an accepted start to its unitStart; no same-cycle bypass.
REQ-014 SHALL support simultaneous push and pop: occupancy unchanged, order preserved (strict FIFO).
REQ-015 SHALL wrap read/write pointers modulo FIFO_DEPTH; occupancy is held in a separate counter of width log2(FIFO_DEPTH)+1.
REQ-016 SHALL drive busy = (occupancy != 0) || |unitBusy.
REQ-017 SHALL, on flush, set occupancy and both FIFO pointers to 0 the next cycle, keep rrPtr, and perform no push or dispatch that cycle.

Reset
REQ-018 SHALL, on reset low, asynchronously clear occupancy, pointers, rrPtr and statistics counters; outputs SHALL read ready=1, busy=|unitBusy, unitStart=0.
REQ-019 SHALL discard jobs in flight in the FIFO on reset mid-operation; already-dispatched unit work is unaffected.

Configuration
REQ-020 SHALL compile the statistics block only when RAY_DISPATCH_STATS_EN is defined: dispatchCount increments per dispatch, stallCount increments per cycle with occupancy>0 and no unitReady; both saturate at 2^32-1 and clear on reset only (not on flush).
REQ-021 SHALL, without RAY_DISPATCH_STATS_EN, omit the dispatchCount/stallCount ports and all related logic; dispatch behaviour is identical.

Verification
REQ-022 SHALL cover: NUM_UNITS=4, all unitReady=1, 4 back-to-back starts -> unitStart 0001,0010,0100,1000 on cycles 1..4.
REQ-023 SHALL cover: unitReady=0100, rrPtr=0, one job -> unitStart=0100, rrPtr becomes 3.
REQ-024 SHALL cover: unitReady=0, FIFO_DEPTH=4, 5 starts -> ready low after 4th, 5th ignored, busy=1; stallCount=4 after 4 cycles with macro.
REQ-025 SHALL cover: FIFO full, start with unitReady=0001 -> push blocked (ready=0), one pop; next cycle ready=1, occupancy=3.
REQ-026 SHALL cover: 3 jobs buffered, flush pulse -> no unitStart, occupancy=0 next cycle, rrPtr unchanged.
REQ-027 SHALL cover: reset low mid-burst with 2 jobs queued -> unitStart=0 immediately, ready=1, dispatchCount=0 after release.
